// File: rtl/carry_look_ahead_adder_if.sv
// Operand/result bundle for the carry-look-ahead adder.
// The master drives the operands and carry-in. The slave (the adder) returns the registered sum and flags.
interface carry_look_ahead_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output a, b, cin,
    input  result, cout, overflow
  );

  modport slave (
    input  a, b, cin,
    output result, cout, overflow
  );
endinterface

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry-look-ahead adder with a registered sum, carry-out and signed-overflow flag.
// The carries inside each GROUP-bit block and the carries between blocks are both flattened sum-of-products terms.
module carry_look_ahead_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  carry_look_ahead_adder_if.slave    add_if
);

  localparam int NGRP = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || GROUP < 1) begin : g_param_check
    $error("WIDTH must be a non-zero multiple of GROUP");
  end

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    blk_c;
  logic             term;
  logic             acc;

  logic [WIDTH-1:0] result_d, result_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  // Signed overflow: the carry into the MSB disagrees with the carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

  always_comb begin
    g      = add_if.a & add_if.b;
    p      = add_if.a ^ add_if.b;
    grp_g  = '0;
    grp_p  = '0;
    blk_c  = '0;
    c      = '0;
    term   = 1'b0;
    acc    = 1'b0;

    for (int k = 0; k < NGRP; k++) begin
      grp_p[k] = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        term = g[k*GROUP + j];
        for (int m = j + 1; m < GROUP; m++) begin
          term = term & p[k*GROUP + m];
        end
        grp_g[k] = grp_g[k] | term;
        grp_p[k] = grp_p[k] & p[k*GROUP + j];
      end
    end

    // Second level: every block carry-in is taken straight from cin and the group G/P terms.
    blk_c[0] = add_if.cin;
    for (int k = 0; k < NGRP; k++) begin
      term = add_if.cin;
      for (int j = 0; j <= k; j++) begin
        term = term & grp_p[j];
      end
      acc = term;
      for (int j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      blk_c[k+1] = acc;
    end

    for (int k = 0; k < NGRP; k++) begin
      c[k*GROUP] = blk_c[k];
      for (int j = 1; j < GROUP; j++) begin
        term = blk_c[k];
        for (int m = 0; m < j; m++) begin
          term = term & p[k*GROUP + m];
        end
        acc = term;
        for (int i = 0; i < j; i++) begin
          term = g[k*GROUP + i];
          for (int m = i + 1; m < j; m++) begin
            term = term & p[k*GROUP + m];
          end
          acc = acc | term;
        end
        c[k*GROUP + j] = acc;
      end
    end
    c[WIDTH] = blk_c[NGRP];

    result_d = p ^ c[WIDTH-1:0];
    cout_d   = c[WIDTH];
    ovf_d    = signed_ovf(c[WIDTH-1], c[WIDTH]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign add_if.result   = result_q;
  assign add_if.cout     = cout_q;
  assign add_if.overflow = ovf_q;

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Scoreboard bench for carry_look_ahead_adder: directed corner cases plus random operands.
// Expected results come from plain integer addition.
module tb_carry_look_ahead_adder;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  exp_t sb_q[$];

  carry_look_ahead_adder_if #(.WIDTH(W)) bus ();

  carry_look_ahead_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .add_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t e;
    logic [W:0] full;
    full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    e.result = full[W-1:0];
    e.cout   = full[W];
    e.ovf    = (a[W-1] == b[W-1]) && (e.result[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got result=%h cout=%b ovf=%b, want result=%h cout=%b ovf=%b",
               name, act.result, act.cout, act.ovf, exp.result, exp.cout, exp.ovf);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t o;
    o.result = bus.result;
    o.cout   = bus.cout;
    o.ovf    = bus.overflow;
    return o;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(posedge clk);
    #2;
    bus.a   = a;
    bus.b   = b;
    bus.cin = ci;
    sb_q.push_back(model(a, b, ci));
  endtask

  // Monitor: one registered result appears after every capture edge that had stimulus queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("scoreboard", dut_out(), e);
      end
    end
  end

  logic [W-1:0] da [11] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFF00, 32'hF000FEFA,
                            32'hF000000A, 32'h0F0A000A, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                            32'h12345678};
  logic [W-1:0] db [11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000007B,
                            32'h000000FF, 32'h000D00FF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                            32'h11111111};
  logic         dc [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    exp_t zero;
    exp_t spec;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_vec = 0;
    n_bad = 0;
    zero  = '0;
    rst     = 1'b0;
    bus.a   = '1;
    bus.b   = '1;
    bus.cin = 1'b1;

    // Asynchronous clear with no clock edge yet.
    #1 rst = 1'b1;
    #1 check("reset_async", dut_out(), zero);
    repeat (3) @(posedge clk);
    #1 check("reset_hold", dut_out(), zero);
    @(negedge clk);
    rst = 1'b0;

    // Spot-check the model itself against hand-derived values.
    spec = '{result: 32'hFFFFFFFE, cout: 1'b0, ovf: 1'b1};
    check("model_posovf", model(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0), spec);
    spec = '{result: 32'h7FFFFFFF, cout: 1'b1, ovf: 1'b1};
    check("model_negovf", model(32'h80000000, 32'hFFFFFFFF, 1'b0), spec);
    spec = '{result: 32'h0F17010A, cout: 1'b0, ovf: 1'b0};
    check("model_cin", model(32'h0F0A000A, 32'h000D00FF, 1'b1), spec);

    for (int i = 0; i < 11; i++) issue(da[i], db[i], dc[i]);

    for (int i = 0; i < 200; i++) begin
      ra = $urandom();
      rb = $urandom();
      case (i % 4)
        0:       issue(ra, ~ra, 1'(i % 8 == 0));
        1:       issue(ra, rb, 1'($urandom_range(0, 1)));
        2:       issue({ra[W-1], {(W-1){ra[0]}}}, rb, 1'($urandom_range(0, 1)));
        default: issue(ra, rb & 32'h0000FFFF, 1'b1);
      endcase
    end

    // Ensure outputs are non-zero, then reset asynchronously mid-cycle.
    issue(32'h00000001, 32'h00000002, 1'b0);
    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(posedge clk);
    #3;
    rst = 1'b1;
    #1 check("reset_mid_async", dut_out(), zero);
    @(posedge clk);
    #1 check("reset_mid_hold", dut_out(), zero);
    @(negedge clk);
    rst = 1'b0;

    issue(32'hFFFFFFFF, 32'h00000000, 1'b1);
    issue(32'h80000000, 32'h80000000, 1'b0);
    for (int i = 0; i < 50; i++) issue($urandom(), $urandom(), 1'($urandom_range(0, 1)));

    for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(posedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results left in queue, want 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
